kim_keypad_display_emu: RTL
===========================

# kim_keypad_display_emu

Peripheral-side model of the KIM-1 keypad and six-digit LED display. It connects to the KIM_1 keyboard/display pins. It answers the monitor's row scan by pulling keypad columns low for a requested key, and it reconstructs the multiplexed LED display into six stable segment registers for a host (front panel, video overlay, UART bridge). All signals are in the KIM_1 clock domain.

## Interface
Parameters:
- HOLD_CYCLES, 20000: cycles a requested key stays pressed (20 ms at 1 MHz).
- RELEASE_CYCLES, 20000: cycles all columns are held released after a press, before the next key is accepted.
- MIN_ON, 4: minimum consecutive cycles a digit must be selected for its segments to be captured.
- PERSIST, 100000: cycles without a valid refresh before a digit is blanked.

Ports:
- clk  in  1  system clock, the same clock as KIM_1.
- reset  in  1  synchronous, active-high.
- KB_ROW  in  4  active-low row select from the KIM_1 '145 outputs 0-3.
- LED_DIG  in  6  active-low digit select, index 0 = KIM digit 4 … index 5 = digit 9.
- LED_SEG  in  7  active-low segments g..a.
- KB_COL  out  7  active-low column return to KIM_1.
- key_valid  in  1  host key request.
- key_code  in  5  key index; row = code/7, column = code%7, valid range 0-20.
- key_ready  out  1  block can accept a key request.
- key_err  out  1  one-cycle pulse when an out-of-range code is accepted.
- seg_out  out  42  captured active-high segments, digit n at [7n+6:7n].
- digit_lit  out  6  digit n was refreshed within PERSIST cycles.

## Operation
Key FSM has three states: IDLE, PRESS, RELEASE.
- IDLE: key_ready=1. A request is accepted when key_valid && key_ready.
  - If key_code ≤ 20: latch row and column, load the hold counter with HOLD_CYCLES-1, go to PRESS.
  - If key_code > 20: pulse key_err, stay in IDLE.
- PRESS: key_ready=0. Decrement the counter; at 0, load RELEASE_CYCLES-1 and go to RELEASE.
- RELEASE: key_ready=0 and all columns are released. At counter 0, go to IDLE.
- Requests made while key_ready=0 are ignored. No queueing.
- KB_COL is combinational from the registered state and the live KB_ROW. KB_COL[c]=0 iff state==PRESS, c equals the latched column, and KB_ROW[latched row]==0. Every other column reads 1.
- Row 3 (the TTY jumper row) is never driven.
- Reset in any state returns the FSM to IDLE with columns released. A key that is mid-press is abandoned.

Display capture:
- A "single select" is a cycle in which exactly one LED_DIG bit is 0.
- Per cycle, register the previous selected-digit index (or none) and the previous ~LED_SEG.
- While the same digit stays singly selected, its on-counter increments and saturates at MIN_ON.
- A change of selection ends the window. This includes deselection, a switch to another digit, or a multiple select.
  - If the window lasted at least MIN_ON cycles, seg_out for that digit gets the ~LED_SEG registered in the window's last cycle, digit_lit[n] is set, and persistence timer n is reloaded to PERSIST-1.
  - A window shorter than MIN_ON is discarded.
- A multiple-select cycle never starts a window.
- Each persistence timer decrements while nonzero. On reaching 0 it clears digit_lit[n] and zeroes that digit's seg_out.
- If a capture and a timer expiry land on the same digit in the same cycle, the capture wins.
- Captures of several digits in one cycle cannot occur, because only one window ends per cycle.

Reset values: KB_COL=7'h7F, key_ready=1 (IDLE), key_err=0, seg_out=0, digit_lit=0, all counters and the window tracker cleared (no digit selected).

## Timing
- Key acceptance: the request is accepted on edge k. State is PRESS from cycle k+1.
- The press lasts exactly HOLD_CYCLES cycles, then RELEASE lasts exactly RELEASE_CYCLES cycles.
- key_ready returns high in cycle k+1+HOLD_CYCLES+RELEASE_CYCLES.
- KB_COL responds to KB_ROW with zero cycles of latency, as a combinational path.
- key_err is high in cycle k+1 only.
- Segment capture: seg_out and digit_lit update one cycle after the first cycle that ends the window.
- Counter widths are $clog2(param+1). All counters wrap-free: they saturate or reload, and never underflow.
- Inputs are synchronous to clk. No synchronizers inside the block.

## Test plan
- Code 5, HOLD=8, RELEASE=4; KB_ROW=4'b1110 held, then 4'b1101.
  - KB_COL=7'h5F only while the row is 0 and in PRESS; KB_COL=7'h7F under row 1.
  - key_ready low for exactly 12 cycles.
- Code 20 with KB_ROW cycling 0→1→2→3.
  - KB_COL=7'h3F only during row 2; all other rows read 7'h7F.
- Code 25.
  - key_err pulses one cycle; key_ready stays 1; KB_COL stays 7'h7F.
- Second key_valid during PRESS.
  - Ignored; only the first key appears on KB_COL.
- Scan digits 0-5 with segment patterns 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, each selected for 10 cycles.
  - seg_out holds those patterns; digit_lit=6'h3F.
  - Then a 2-cycle glitch select on digit 2 with 0x00 leaves its value unchanged.
- PERSIST=50: stop the scan after a capture of digit 3.
  - Exactly 50 cycles after its capture, digit_lit[3]=0 and seg_out[27:21]=0.
  - Assert reset mid-PRESS: KB_COL=7'h7F and key_ready=1 the next cycle.

Source files
------------

// File: rtl/kim_keypad_display_emu.sv
// KIM-1 keypad / LED display peripheral model: presses one requested key against
// the monitor's row scan and rebuilds the multiplexed display into stable registers.

module kim_digit_slot #(
    parameter int PERSIST = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cap,
    input  logic [6:0] cap_seg,
    output logic [6:0] seg,
    output logic       lit
);
    localparam int TW = $clog2(PERSIST + 1);
    localparam logic [TW-1:0] RELOAD = TW'(PERSIST - 1);

    logic [TW-1:0] tmr;

    // A fresh capture beats an expiry landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr <= '0;
            seg <= '0;
            lit <= 1'b0;
        end else if (cap) begin
            tmr <= RELOAD;
            seg <= cap_seg;
            lit <= 1'b1;
        end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
        end else begin
            seg <= '0;
            lit <= 1'b0;
        end
    end
endmodule

module kim_keypad_display_emu #(
    parameter int HOLD_CYCLES    = 20000,
    parameter int RELEASE_CYCLES = 20000,
    parameter int MIN_ON         = 4,
    parameter int PERSIST        = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  KB_ROW,
    input  logic [5:0]  LED_DIG,
    input  logic [6:0]  LED_SEG,
    output logic [6:0]  KB_COL,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        key_ready,
    output logic        key_err,
    output logic [41:0] seg_out,
    output logic [5:0]  digit_lit
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int KW = (HW > RW) ? HW : RW;
    localparam int OW = $clog2(MIN_ON + 1);

    localparam logic [KW-1:0] HOLD_LOAD = KW'(HOLD_CYCLES - 1);
    localparam logic [KW-1:0] REL_LOAD  = KW'(RELEASE_CYCLES - 1);
    localparam logic [OW-1:0] MIN_ON_C  = OW'(MIN_ON);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] key_cnt;
    logic [1:0]    row_q;
    logic [2:0]    col_q;
    logic [1:0]    code_row;
    logic [2:0]    code_col;

    assign key_ready = (state == ST_IDLE);

    // code/7 and code%7 without a divider; only meaningful for codes 0-20.
    always_comb begin
        if (key_code >= 5'd14) begin
            code_row = 2'd2;
            code_col = 3'(key_code - 5'd14);
        end else if (key_code >= 5'd7) begin
            code_row = 2'd1;
            code_col = 3'(key_code - 5'd7);
        end else begin
            code_row = 2'd0;
            code_col = 3'(key_code);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            key_cnt <= '0;
            row_q   <= '0;
            col_q   <= '0;
            key_err <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        if (key_code > 5'd20) begin
                            key_err <= 1'b1;
                        end else begin
                            row_q   <= code_row;
                            col_q   <= code_col;
                            key_cnt <= HOLD_LOAD;
                            state   <= ST_PRESS;
                        end
                    end
                end
                ST_PRESS: begin
                    if (key_cnt == '0) begin
                        key_cnt <= REL_LOAD;
                        state   <= ST_RELEASE;
                    end else begin
                        key_cnt <= key_cnt - KW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (key_cnt == '0) state   <= ST_IDLE;
                    else               key_cnt <= key_cnt - KW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Live row feeds the column return directly so the monitor sees it in the scan cycle.
    always_comb begin
        KB_COL = 7'h7F;
        if (state == ST_PRESS && row_q != 2'd3 && !KB_ROW[row_q])
            KB_COL[col_q] = 1'b0;
    end

    logic [2:0]    cur_idx;
    logic [2:0]    sel_cnt;
    logic          cur_single;
    logic          win_vld;
    logic [2:0]    win_idx;
    logic [6:0]    win_seg;
    logic [OW-1:0] on_cnt;
    logic          same;
    logic          cap;

    always_comb begin
        sel_cnt = '0;
        cur_idx = '0;
        for (int i = 0; i < 6; i++) begin
            if (!LED_DIG[i]) begin
                sel_cnt = sel_cnt + 3'd1;
                cur_idx = 3'(i);
            end
        end
        cur_single = (sel_cnt == 3'd1);
    end

    assign same = cur_single && win_vld && (cur_idx == win_idx);
    assign cap  = win_vld && !same && (on_cnt >= MIN_ON_C);

    // win_seg always trails by one cycle, so at window end it holds the last in-window segments.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_vld <= 1'b0;
            win_idx <= '0;
            win_seg <= '0;
            on_cnt  <= '0;
        end else begin
            win_seg <= ~LED_SEG;
            if (same) begin
                if (on_cnt != MIN_ON_C) on_cnt <= on_cnt + OW'(1);
            end else begin
                win_vld <= cur_single;
                win_idx <= cur_idx;
                on_cnt  <= cur_single ? OW'(1) : '0;
            end
        end
    end

    logic [5:0][6:0] seg_q;

    for (genvar n = 0; n < 6; n++) begin : g_slot
        kim_digit_slot #(.PERSIST(PERSIST)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .cap     (cap && (win_idx == 3'(n))),
            .cap_seg (win_seg),
            .seg     (seg_q[n]),
            .lit     (digit_lit[n])
        );
    end

    assign seg_out = seg_q;
endmodule
